// File: rtl/vga_scanout_if.sv
// Framebuffer read port: the scanout issues rd_en/rd_addr, the memory answers
// with rd_data exactly one clk later.
interface vga_scanout_if;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [2:0]  rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// Raster-order framebuffer reader with 2x pixel/line doubling driving a VGA DAC.
// Everything advances on a divide-by-2 pixel tick derived from the system clock.
module vga_scanout #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master fb,
  output logic          frame_start,
  output logic [9:0]    VGA_R,
  output logic [9:0]    VGA_G,
  output logic [9:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC,
  output logic          VGA_CLK
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsStop  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VsStop  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        pix_en_q, pix_en_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [16:0] rd_addr_q, rd_addr_d;
  logic        hs_s1_q, hs_s1_d;
  logic        vs_s1_q, vs_s1_d;
  logic        blank_s1_q, blank_s1_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic [2:0]  colour_q, colour_d;
  logic        frame_start_q, frame_start_d;
  logic        vga_clk_q, vga_clk_d;

  logic        visible;
  logic [16:0] x_ext, y_ext, addr;

  assign visible = (h_cnt_q < HVis) && (v_cnt_q < VVis);
  assign x_ext   = 17'(h_cnt_q[9:1]);
  assign y_ext   = 17'(v_cnt_q[9:1]);
  // y*320 built from shifts: 320 = 256 + 64
  assign addr    = (y_ext << 8) + (y_ext << 6) + x_ext;

  always_comb begin
    pix_en_d      = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    hs_s1_d       = hs_s1_q;
    vs_s1_d       = vs_s1_q;
    blank_s1_d    = blank_s1_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    colour_d      = colour_q;
    frame_start_d = 1'b0;
    // Low on tick clks so the DAC samples in the middle of each pixel
    vga_clk_d     = pix_en_q;

    if (pix_en_q) begin
      rd_en_d    = visible;
      rd_addr_d  = visible ? addr : '0;
      hs_s1_d    = !((h_cnt_q >= HsStart) && (h_cnt_q < HsStop));
      vs_s1_d    = !((v_cnt_q >= VsStart) && (v_cnt_q < VsStop));
      blank_s1_d = visible;

      // Second stage lines sync/blank up with the colour returned for the same pixel
      hs_d     = hs_s1_q;
      vs_d     = vs_s1_q;
      blank_d  = blank_s1_q;
      colour_d = blank_s1_q ? fb.rd_data : 3'b000;

      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        if (v_cnt_q == VLast) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      blank_s1_q    <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      colour_q      <= '0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      blank_s1_q    <= blank_s1_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      colour_q      <= colour_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign fb.rd_en    = rd_en_q;
  assign fb.rd_addr  = rd_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = {10{colour_q[2]}};
  assign VGA_G       = {10{colour_q[1]}};
  assign VGA_B       = {10{colour_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_SYNC    = 1'b0;
  assign VGA_CLK     = vga_clk_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full 640x480 instance plus a shrunken-timing instance so
// whole frames fit in a short run; both are compared every clk against a timing model.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // Index 0: full VGA timing, index 1: small timing
  int hv [2] = '{640, 40};
  int hf [2] = '{16, 4};
  int hsw[2] = '{96, 6};
  int hb [2] = '{48, 6};
  int vv [2] = '{480, 20};
  int vf [2] = '{10, 2};
  int vsw[2] = '{2, 2};
  int vb [2] = '{33, 3};

  vga_scanout_if fb_full ();
  vga_scanout_if fb_small ();

  logic       fs_f, hs_f, vs_f, bl_f, sy_f, ck_f;
  logic       fs_s, hs_s, vs_s, bl_s, sy_s, ck_s;
  logic [9:0] r_f, g_f, b_f, r_s, g_s, b_s;

  vga_scanout u_full (
    .clk(clk), .rst(rst), .fb(fb_full), .frame_start(fs_f),
    .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f), .VGA_HS(hs_f), .VGA_VS(vs_f),
    .VGA_BLANK(bl_f), .VGA_SYNC(sy_f), .VGA_CLK(ck_f)
  );

  vga_scanout #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .clk(clk), .rst(rst), .fb(fb_small), .frame_start(fs_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_BLANK(bl_s), .VGA_SYNC(sy_s), .VGA_CLK(ck_s)
  );

  // Random framebuffer; unread cycles return garbage to prove it is ignored
  logic [2:0] mem [76800];
  always @(posedge clk) begin
    fb_full.rd_data  <= fb_full.rd_en  ? mem[fb_full.rd_addr]  : 3'($urandom);
    fb_small.rd_data <= fb_small.rd_en ? mem[fb_small.rd_addr] : 3'($urandom);
  end

  typedef struct {
    logic        rd_en;
    logic [16:0] rd_addr;
    logic        fs, hs, vs, blank, vclk;
    logic [9:0]  r, g, b;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int k;
  logic prev_hs, prev_vs;
  int   hs_fall_k, vs_fall_k, fs_k, fs_cnt, max_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs k clks after reset release (k=0 means still in/just out of reset).
  // Pixel tick n lands on clk 2n+2; its outputs appear one tick later, at clk 2n+4.
  function automatic exp_t model(input int i, input int kk);
    exp_t e;
    int ht, vt, kt, n, p, h, v;
    logic [2:0] c;
    bit vis;
    e = '{rd_en: 1'b0, rd_addr: '0, fs: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b0,
          vclk: 1'b0, r: '0, g: '0, b: '0};
    ht = hv[i] + hf[i] + hsw[i] + hb[i];
    vt = vv[i] + vf[i] + vsw[i] + vb[i];
    if (kk > 0) begin
      kt = kk - (kk % 2);
      e.vclk = (kk % 2 == 0);
      if (kt >= 2) begin
        n = kt / 2 - 1;
        p = n % (ht * vt);
        h = p % ht;
        v = p / ht;
        vis = (h < hv[i]) && (v < vv[i]);
        e.rd_addr = vis ? 17'((v / 2) * 320 + h / 2) : 17'd0;
        if (kk % 2 == 0) begin
          e.rd_en = vis;
          e.fs = (h == ht - 1) && (v == vt - 1);
        end
      end
      if (kt >= 4) begin
        n = kt / 2 - 2;
        p = n % (ht * vt);
        h = p % ht;
        v = p / ht;
        vis = (h < hv[i]) && (v < vv[i]);
        e.hs = !((h >= hv[i] + hf[i]) && (h < hv[i] + hf[i] + hsw[i]));
        e.vs = !((v >= vv[i] + vf[i]) && (v < vv[i] + vf[i] + vsw[i]));
        e.blank = vis;
        if (vis) begin
          c = mem[(v / 2) * 320 + h / 2];
          e.r = {10{c[2]}};
          e.g = {10{c[1]}};
          e.b = {10{c[0]}};
        end
      end
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t e;
    e = model(0, k);
    chk("full.rd_en", 32'(fb_full.rd_en), 32'(e.rd_en));
    chk("full.rd_addr", 32'(fb_full.rd_addr), 32'(e.rd_addr));
    chk("full.frame_start", 32'(fs_f), 32'(e.fs));
    chk("full.hs", 32'(hs_f), 32'(e.hs));
    chk("full.vs", 32'(vs_f), 32'(e.vs));
    chk("full.blank", 32'(bl_f), 32'(e.blank));
    chk("full.rgb", {2'b0, r_f, g_f, b_f}, {2'b0, e.r, e.g, e.b});
    chk("full.sync", 32'(sy_f), 32'd0);
    chk("full.vga_clk", 32'(ck_f), 32'(e.vclk));
    e = model(1, k);
    chk("small.rd_en", 32'(fb_small.rd_en), 32'(e.rd_en));
    chk("small.rd_addr", 32'(fb_small.rd_addr), 32'(e.rd_addr));
    chk("small.frame_start", 32'(fs_s), 32'(e.fs));
    chk("small.hs", 32'(hs_s), 32'(e.hs));
    chk("small.vs", 32'(vs_s), 32'(e.vs));
    chk("small.blank", 32'(bl_s), 32'(e.blank));
    chk("small.rgb", {2'b0, r_s, g_s, b_s}, {2'b0, e.r, e.g, e.b});
    chk("small.sync", 32'(sy_s), 32'd0);
    chk("small.vga_clk", 32'(ck_s), 32'(e.vclk));
  endtask

  task automatic clear_trackers();
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    hs_fall_k = -1;
    vs_fall_k = -1;
    fs_k = -1;
    fs_cnt = 0;
    max_addr = 0;
  endtask

  // One free-running clk with model comparison and sync/frame measurements
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check_all();
    if (k == 2) chk("full.first_read_en", 32'(fb_full.rd_en), 32'd1);
    if (k == 3206) chk("full.addr_2_2", 32'(fb_full.rd_addr), 32'd321);
    if (prev_hs && !hs_f) begin
      if (hs_fall_k < 0) chk("full.hs_first_fall", k, 1316);
      else chk("full.hs_period", k - hs_fall_k, 1600);
      hs_fall_k = k;
    end
    if (!prev_hs && hs_f) chk("full.hs_low_clks", k - hs_fall_k, 192);
    prev_hs = hs_f;
    if (prev_vs && !vs_s) begin
      chk("small.vs_fall_pos", (k - 4) % 3024, 2464);
      vs_fall_k = k;
    end
    if (!prev_vs && vs_s) chk("small.vs_low_clks", k - vs_fall_k, 224);
    prev_vs = vs_s;
    if (fs_s) begin
      if (fs_k < 0) chk("small.first_frame_start", k, 3024);
      else chk("small.frame_period", k - fs_k, 3024);
      fs_k = k;
      fs_cnt++;
    end
    if (fb_small.rd_en && int'(fb_small.rd_addr) > max_addr) max_addr = int'(fb_small.rd_addr);
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) mem[i] = 3'($urandom);
    clear_trackers();

    // Power-on reset held 3 clks
    k = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Two small frames, then stop mid-frame at (h=30, v=12) of the third
    for (int i = 0; i < 3024 * 2 + 1406; i++) step();
    chk("small.frame_count", fs_cnt, 2);
    chk("small.max_addr", max_addr, 9 * 320 + 19);

    // Single-clk reset mid-frame
    rst = 1'b1;
    @(posedge clk);
    #1;
    k = 0;
    check_all();
    rst = 1'b0;
    clear_trackers();

    for (int i = 0; i < 3024 * 2 + 200; i++) step();
    chk("small.frame_count_after_reset", fs_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the pixel framebuffer. The word-guesser drawing FSM writes 3-bit colour pixels at 320x240 coordinates. This block reads that framebuffer in raster order, applies 2x pixel doubling, and drives a 640x480 @ 60 Hz VGA DAC. It generates all sync, blank and DAC-clock signals from the 50 MHz system clock using a divide-by-2 pixel enable.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  17  framebuffer word address, y*320+x
- rd_data  in  3  pixel colour {R,G,B}; valid exactly 1 clk after rd_addr/rd_en
- frame_start  out  1  one-clk pulse at the start of each frame
- VGA_R, VGA_G, VGA_B  out  10 each  DAC colour
- VGA_HS, VGA_VS  out  1 each  syncs, active-low
- VGA_BLANK  out  1  active-low blank
- VGA_SYNC  out  1  constant 0
- VGA_CLK  out  1  25 MHz DAC clock

## Operation
- pix_en toggles every clk. It is 0 in the first cycle after reset. A "pixel tick" is a clk with pix_en=1.
- h_cnt runs 0..H_TOTAL-1 (800). v_cnt runs 0..V_TOTAL-1 (525).
  - h_cnt advances on each tick.
  - At h_cnt=799, h_cnt wraps to 0 and v_cnt increments.
  - At (799,524), both counters wrap to (0,0).
- visible = (h_cnt<640) && (v_cnt<480).
- Address generation, on each tick:
  - x = h_cnt>>1, y = v_cnt>>1.
  - rd_addr <= (y<<8)+(y<<6)+x. No multiplier. Maximum value is 76799.
  - rd_en <= visible.
  - When not visible, rd_addr <= 0.
  - On non-tick clks, rd_en <= 0 and rd_addr holds its value.
- Sync and blank, computed from the counters on each tick, then delayed one tick (see Timing):
  - hs_n = 0 when h_cnt is in [656,751].
  - vs_n = 0 when v_cnt is in [490,491].
  - blank_n = visible.
- Colour:
  - On the tick after the read, capture rd_data. Each bit is replicated 10x: VGA_R={10{c[2]}}, VGA_G={10{c[1]}}, VGA_B={10{c[0]}}.
  - All colour outputs are 0 when the delayed blank_n is 0.
- VGA_CLK: registered. It is 1 during non-tick clks and 0 during tick clks, so its rising edge falls mid-pixel.
- frame_start: 1 for the single clk of the tick on which the counters wrap (799,524)->(0,0).
- Framebuffer reads occur only during visible pixels. The block never writes.

## Timing
- Reset values (all outputs, registered):
  - VGA_HS=1, VGA_VS=1, VGA_BLANK=0, VGA_R/G/B=0, VGA_SYNC=0, VGA_CLK=0.
  - rd_en=0, rd_addr=0, frame_start=0.
  - h_cnt=0, v_cnt=0, pix_en=0.
- Reset asserted mid-frame: on the next clk, all state returns to the reset values above. The first pixel tick after release is at the 2nd clk. Scanning resumes at (0,0) with no partial line.
- Pipeline:
  - Tick N: counters at (h,v); rd_addr/rd_en registered.
  - Clk N+1: rd_data valid.
  - Tick N+1 (2 clks after tick N): RGB, HS, VS and BLANK show pixel (h,v).
  - Sync and blank therefore stay aligned with colour: one pixel-tick latency for everything.
- Per line: 800 ticks = 1600 clks. Per frame: 525 lines = 840000 clks.
- Each framebuffer address is read twice per line (pixel doubling) and on two consecutive line pairs (line doubling).
- rd_data is ignored except in the clk after rd_en=1.

## Test plan
- Reset: hold rst for 3 clks, then check every output equals its reset value. Release rst: first rd_en=1 occurs 1 clk after release with rd_addr=0. First non-blank RGB appears 2 clks later.
- Horizontal sync: free-run one line and measure VGA_HS. Low for exactly 96 ticks (192 clks); falling edge 656 ticks after the first visible pixel; period 1600 clks.
- Vertical sync: run one frame. VGA_VS is low for exactly 2 lines (3200 clks) starting at line 490. frame_start pulses exactly once every 840000 clks.
- Addressing: at (h=2,v=2), rd_addr=321. At (639,479), rd_addr=76799. Reads at (0,0),(1,0),(0,1),(1,1) all give rd_addr=0. No rd_en=1 for h_cnt>=640 or v_cnt>=480.
- Colour and blank: model returns rd_data=3'b101 for every address. Visible output is R=10'h3FF, G=0, B=10'h3FF. During blank, all three are 0 and VGA_BLANK=0.
- Mid-frame reset: assert rst at (h=300,v=200) for 1 clk. Next frame_start occurs exactly 840000 clks after release, plus pipeline offset. HS/VS periods are unchanged afterward.
